// File: rtl/reservation_station_pkg.sv
// Shared constants for the reservation station and the ALU: default tag/entry widths
// and the ALU operation encodings.
package reservation_station_pkg;

   localparam int DEF_ROB_SIZE_WIDTH = 4;
   localparam int DEF_RS_SIZE_WIDTH  = 3;

   typedef enum logic [2:0] {
      ALU_ADD_SUB = 3'b000,
      ALU_SLL     = 3'b001,
      ALU_SLT     = 3'b010,
      ALU_SLTU    = 3'b011,
      ALU_XOR     = 3'b100,
      ALU_SRL_SRA = 3'b101,
      ALU_OR      = 3'b110,
      ALU_AND     = 3'b111
   } alu_op_l1_e;

   localparam logic ALU_SUB = 1'b1;
   localparam logic ALU_SRA = 1'b1;

endpackage

// File: rtl/reservation_station_select.sv
// rs_select: lowest-index priority encoder returning the index of the first set
// request bit and a found flag.
module rs_select #(
   parameter int IDX_W = 3
) (
   input  logic [(1<<IDX_W)-1:0] req,
   output logic [IDX_W-1:0]      idx,
   output logic                  found
);

   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = (1 << IDX_W) - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx   = IDX_W'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/reservation_station.sv
// ALU reservation station: buffers issued ops until operands arrive on the CDBs and
// dispatches one ready op per cycle. Define RS_CDB_BYPASS_EN for same-cycle CDB bypass.
module reservation_station
   import reservation_station_pkg::*;
#(
   parameter int RS_SIZE_WIDTH  = DEF_RS_SIZE_WIDTH,
   parameter int ROB_SIZE_WIDTH = DEF_ROB_SIZE_WIDTH
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic                      rdy_in,
   input  logic                      need_flush_in,
   input  logic                      issue_valid_in,
   input  logic [31:0]               issue_vj_in,
   input  logic [31:0]               issue_vk_in,
   input  logic                      issue_qj_has_dep_in,
   input  logic                      issue_qk_has_dep_in,
   input  logic [ROB_SIZE_WIDTH-1:0] issue_qj_in,
   input  logic [ROB_SIZE_WIDTH-1:0] issue_qk_in,
   input  logic [ROB_SIZE_WIDTH-1:0] issue_rob_id_in,
   input  logic [2:0]                issue_op_L1_in,
   input  logic                      issue_op_L2_in,
   input  logic                      cdb_alu_ready_in,
   input  logic [ROB_SIZE_WIDTH-1:0] cdb_alu_rob_id_in,
   input  logic [31:0]               cdb_alu_value_in,
   input  logic                      cdb_lsb_ready_in,
   input  logic [ROB_SIZE_WIDTH-1:0] cdb_lsb_rob_id_in,
   input  logic [31:0]               cdb_lsb_value_in,
   output logic                      valid_out,
   output logic [31:0]               opr1_out,
   output logic [31:0]               opr2_out,
   output logic [ROB_SIZE_WIDTH-1:0] rob_id_out,
   output logic [2:0]                op_L1_out,
   output logic                      op_L2_out,
   output logic                      full_out
);

   localparam int N = 1 << RS_SIZE_WIDTH;

   logic [N-1:0]              busy, busy_nxt, qj_dep, qk_dep, op_l2;
   logic [31:0]               vj     [N];
   logic [31:0]               vk     [N];
   logic [ROB_SIZE_WIDTH-1:0] qj     [N];
   logic [ROB_SIZE_WIDTH-1:0] qk     [N];
   logic [ROB_SIZE_WIDTH-1:0] rob_id [N];
   logic [2:0]                op_l1  [N];

   logic [N-1:0]              ready_vec;
   logic [RS_SIZE_WIDTH-1:0]  free_idx, ready_idx;
   logic                      free_found, ready_found;
   logic [31:0]               opr1_sel, opr2_sel;

   function automatic logic cdb_hit(input logic [ROB_SIZE_WIDTH-1:0] tag);
      return (cdb_alu_ready_in && cdb_alu_rob_id_in == tag) ||
             (cdb_lsb_ready_in && cdb_lsb_rob_id_in == tag);
   endfunction

   // ALU wins when both buses carry the same tag.
   function automatic logic [31:0] cdb_val(input logic [ROB_SIZE_WIDTH-1:0] tag);
      return (cdb_alu_ready_in && cdb_alu_rob_id_in == tag) ? cdb_alu_value_in
                                                            : cdb_lsb_value_in;
   endfunction

   function automatic int popcount(input logic [N-1:0] v);
      int c;
      c = 0;
      for (int i = 0; i < N; i++) c += int'(v[i]);
      return c;
   endfunction

   always_comb begin
      for (int i = 0; i < N; i++) begin
`ifdef RS_CDB_BYPASS_EN
         ready_vec[i] = busy[i] && (!qj_dep[i] || cdb_hit(qj[i])) &&
                                   (!qk_dep[i] || cdb_hit(qk[i]));
`else
         ready_vec[i] = busy[i] && !qj_dep[i] && !qk_dep[i];
`endif
      end
   end

   rs_select #(.IDX_W(RS_SIZE_WIDTH)) u_free_sel (
      .req   (~busy),
      .idx   (free_idx),
      .found (free_found)
   );

   rs_select #(.IDX_W(RS_SIZE_WIDTH)) u_ready_sel (
      .req   (ready_vec),
      .idx   (ready_idx),
      .found (ready_found)
   );

   always_comb begin
`ifdef RS_CDB_BYPASS_EN
      opr1_sel = qj_dep[ready_idx] ? cdb_val(qj[ready_idx]) : vj[ready_idx];
      opr2_sel = qk_dep[ready_idx] ? cdb_val(qk[ready_idx]) : vk[ready_idx];
`else
      opr1_sel = vj[ready_idx];
      opr2_sel = vk[ready_idx];
`endif
   end

   // Free slot and ready slot both come from start-of-cycle busy, so they never collide.
   always_comb begin
      busy_nxt = busy;
      if (rdy_in) begin
         if (need_flush_in) begin
            busy_nxt = '0;
         end else begin
            if (issue_valid_in && free_found) busy_nxt[free_idx] = 1'b1;
            if (ready_found) busy_nxt[ready_idx] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         busy       <= '0;
         full_out   <= 1'b0;
         valid_out  <= 1'b0;
         opr1_out   <= '0;
         opr2_out   <= '0;
         rob_id_out <= '0;
         op_L1_out  <= '0;
         op_L2_out  <= 1'b0;
      end else if (!rdy_in) begin
         valid_out <= 1'b0;
      end else begin
         busy     <= busy_nxt;
         full_out <= (popcount(busy_nxt) == N);
         if (!need_flush_in && ready_found) begin
            valid_out  <= 1'b1;
            opr1_out   <= opr1_sel;
            opr2_out   <= opr2_sel;
            rob_id_out <= rob_id[ready_idx];
            op_L1_out  <= op_l1[ready_idx];
            op_L2_out  <= op_l2[ready_idx];
         end else begin
            valid_out <= 1'b0;
         end
      end
   end

   // Entry payload carries no reset; busy alone qualifies it.
   always_ff @(posedge clk_in) begin
      if (rdy_in && !need_flush_in) begin
         for (int i = 0; i < N; i++) begin
            if (issue_valid_in && free_found && free_idx == RS_SIZE_WIDTH'(i)) begin
               qj_dep[i] <= issue_qj_has_dep_in && !cdb_hit(issue_qj_in);
               qk_dep[i] <= issue_qk_has_dep_in && !cdb_hit(issue_qk_in);
               vj[i]     <= (issue_qj_has_dep_in && cdb_hit(issue_qj_in)) ?
                            cdb_val(issue_qj_in) : issue_vj_in;
               vk[i]     <= (issue_qk_has_dep_in && cdb_hit(issue_qk_in)) ?
                            cdb_val(issue_qk_in) : issue_vk_in;
               qj[i]     <= issue_qj_in;
               qk[i]     <= issue_qk_in;
               rob_id[i] <= issue_rob_id_in;
               op_l1[i]  <= issue_op_L1_in;
               op_l2[i]  <= issue_op_L2_in;
            end else if (busy[i]) begin
               if (qj_dep[i] && cdb_hit(qj[i])) begin
                  vj[i]     <= cdb_val(qj[i]);
                  qj_dep[i] <= 1'b0;
               end
               if (qk_dep[i] && cdb_hit(qk[i])) begin
                  vk[i]     <= cdb_val(qk[i]);
                  qk_dep[i] <= 1'b0;
               end
            end
         end
      end
   end

endmodule
